// File: rtl/disp_pkg.sv
// disp_pkg: the character-code table shared by the game FSM, which produces
// the codes, and the display side, which consumes them.
//   disp_code_t : 7-bit code {en, ch[4:0], dp_n}
//   CH_*        : character codes for the 5-bit ch field
//   seg_decode  : ch -> active-low {g,f,e,d,c,b,a}
package disp_pkg;

    typedef struct packed {
        logic       en;    // 1 = digit lit
        logic [4:0] ch;    // character code
        logic       dp_n;  // 0 = decimal point on
    } disp_code_t;

    // Bit positions of the fields inside the 7-bit code, for code that
    // handles raw vectors rather than disp_code_t.
    localparam int CODE_EN_BIT = 6;
    localparam int CODE_CH_LSB = 1;
    localparam int CODE_CH_W   = 5;
    localparam int CODE_DP_BIT = 0;

    localparam logic [4:0] CH_0     = 5'h00;
    localparam logic [4:0] CH_1     = 5'h01;
    localparam logic [4:0] CH_2     = 5'h02;
    localparam logic [4:0] CH_3     = 5'h03;
    localparam logic [4:0] CH_4     = 5'h04;
    localparam logic [4:0] CH_J     = 5'h05;
    localparam logic [4:0] CH_S     = 5'h06;
    localparam logic [4:0] CH_E     = 5'h07;
    localparam logic [4:0] CH_T     = 5'h08;
    localparam logic [4:0] CH_U     = 5'h09;
    localparam logic [4:0] CH_P     = 5'h0A;
    localparam logic [4:0] CH_B     = 5'h0B;
    localparam logic [4:0] CH_C     = 5'h0C;
    localparam logic [4:0] CH_L     = 5'h0D;
    localparam logic [4:0] CH_Y     = 5'h0E;
    localparam logic [4:0] CH_G     = 5'h0F;
    localparam logic [4:0] CH_BLANK = 5'h10;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Disabled, blank, dp off: what the shadow register holds out of reset.
    localparam disp_code_t CODE_RESET = '{en: 1'b0, ch: CH_BLANK, dp_n: 1'b1};

    function automatic logic [6:0] seg_decode(input logic [4:0] ch);
        logic [6:0] s;
        s = SEG_OFF;  // 0x10 and every unassigned code show blank
        case (ch)
            CH_0: s = 7'h40;
            CH_1: s = 7'h79;
            CH_2: s = 7'h24;
            CH_3: s = 7'h30;
            CH_4: s = 7'h19;
            CH_J: s = 7'h61;
            CH_S: s = 7'h12;
            CH_E: s = 7'h06;
            CH_T: s = 7'h07;
            CH_U: s = 7'h41;
            CH_P: s = 7'h0C;
            CH_B: s = 7'h03;
            CH_C: s = 7'h46;
            CH_L: s = 7'h47;
            CH_Y: s = 7'h11;
            CH_G: s = 7'h42;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational character-code to 7-segment decode.
//   ch  : 5-bit character code
//   seg : active-low {g,f,e,d,c,b,a}
module seg7_decode
    import disp_pkg::*;
(
    input  logic [4:0] ch,
    output logic [6:0] seg
);

    assign seg = seg_decode(ch);

endmodule

// File: rtl/disp_scan8.sv
// disp_scan8: eight-digit multiplexed 7-segment scan driver.
//   clock, reset     : system clock, async active-high reset
//   d1..d8           : {en, ch[4:0], dp_n}; d1 is the rightmost digit (an[0])
//   an               : digit anodes, active-low, at most one low at a time
//   seg, dp          : active-low segments {g..a} and decimal point
//   frame_start      : 1-cycle pulse in the cycle after the shadow register loads
// All four outputs are registered, so they show the previous cycle's
// counter/index/shadow state.
module disp_scan8
    import disp_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] d1,
    input  logic [6:0] d2,
    input  logic [6:0] d3,
    input  logic [6:0] d4,
    input  logic [6:0] d5,
    input  logic [6:0] d6,
    input  logic [6:0] d7,
    input  logic [6:0] d8,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int NUM_DIGITS = 8;
    localparam int CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    generate
        if (BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_params
            $error("disp_scan8: BLANK_CYCLES must be in 0..SCAN_DIV-1");
        end
    endgenerate

    logic [CW-1:0]                     cnt;
    logic [2:0]                        idx;
    disp_code_t [NUM_DIGITS-1:0]       sh;
    disp_code_t [NUM_DIGITS-1:0]       din;
    logic       [NUM_DIGITS-1:0][6:0]  seg_lane;

    assign din = {d8, d7, d6, d5, d4, d3, d2, d1};

    // One decoder per shadow entry; the scan index just picks a lane.
    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
            seg7_decode u_dec (
                .ch  (sh[k].ch),
                .seg (seg_lane[k])
            );
        end
    endgenerate

    logic       wrap;
    logic       load;
    disp_code_t cur;
    logic       lit;

    assign wrap = (cnt == CNT_LAST);
    // Loading at the last cycle of slot 7 means the new snapshot is in place
    // exactly when slot 0 starts, so a frame never mixes two snapshots.
    assign load = wrap && (idx == 3'd7);
    assign cur  = sh[idx];
    assign lit  = (cnt >= BLANK_END) && cur.en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Parked on the last cycle of slot 7 so the first edge loads.
            cnt         <= CNT_LAST;
            idx         <= 3'd7;
            sh          <= {NUM_DIGITS{CODE_RESET}};
            an          <= 8'hFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (wrap)
                idx <= idx + 3'd1;  // 7 -> 0 by natural overflow
            if (load)
                sh <= din;
            frame_start <= load;
            if (lit) begin
                an  <= ~(8'd1 << idx);
                seg <= seg_lane[idx];
                dp  <= cur.dp_n;
            end else begin
                an  <= 8'hFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan8.sv
// tb_disp_scan8: randomized and directed checks of disp_scan8 at
// SCAN_DIV=8, BLANK_CYCLES=2 against a time-based reference model.
module tb_disp_scan8;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 8 * SD;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] din [8];
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    disp_scan8 #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clock       (clock),
        .reset       (reset),
        .d1          (din[0]),
        .d2          (din[1]),
        .d3          (din[2]),
        .d4          (din[3]),
        .d5          (din[4]),
        .d6          (din[5]),
        .d7          (din[6]),
        .d8          (din[7]),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    // Reference segment table, indexed by char 0x00..0x10.
    logic [6:0] seg_tbl [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h61,
                                 7'h12, 7'h06, 7'h07, 7'h41, 7'h0C, 7'h03,
                                 7'h46, 7'h47, 7'h11, 7'h42, 7'h7F};

    function automatic logic [6:0] ref_seg(input logic [4:0] c);
        return (c <= 5'd16) ? seg_tbl[c] : 7'h7F;
    endfunction

    function automatic logic [6:0] mk(input bit en, input logic [4:0] c, input bit dpn);
        return {en, c, dpn};
    endfunction

    // Reference model: n counts rising edges since reset released. A load
    // happens on edges 1, 1+FRAME, ...; the display after edge n (n>=2)
    // shows time t=n-2 of the scan: slot t/SD, offset t%SD within the slot.
    int         n;
    logic [6:0] snap [8];
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fs;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            n = 0;
            for (int k = 0; k < 8; k++) snap[k] = 7'h21;
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
        end else begin
            int slot, off;
            n++;
            exp_fs = ((n - 1) % FRAME == 0);
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
            if (n >= 2) begin
                slot = ((n - 2) / SD) % 8;
                off  = (n - 2) % SD;
                if (off >= BC && snap[slot][6]) begin
                    exp_an  = ~(8'd1 << slot);
                    exp_seg = ref_seg(snap[slot][5:1]);
                    exp_dp  = snap[slot][0];
                end
            end
            if (exp_fs)
                for (int k = 0; k < 8; k++) snap[k] = din[k];
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        for (int k = 0; k < 8; k++) din[k] = 7'($urandom);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({an, seg, dp, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_hold got an=%h seg=%h dp=%b fs=%b want FF/7F/1/0", an, seg, dp, frame_start);
        end
        reset = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 2 * FRAME + 1; c++) begin
            @(negedge clock);
            if (frame_start === 1'b1) pulses++;
            n_cmp++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_bad++;
                $display("FAIL reset_run n=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         n, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (c == 1) begin
                n_cmp++;
                if (frame_start !== 1'b1) begin
                    n_bad++;
                    $display("FAIL first_frame_start got %b want 1", frame_start);
                end
            end
        end
        n_cmp++;
        if (pulses != 3) begin
            n_bad++;
            $display("FAIL frame_start_count got %0d want 3", pulses);
        end
    endtask

    task automatic test_full_pattern();
        logic [6:0] want_seg [8] = '{7'h0C, 7'h41, 7'h07, 7'h06, 7'h12, 7'h7F, 7'h79, 7'h61};
        din[7] = mk(1, 5'h05, 1); din[6] = mk(1, 5'h01, 1);
        din[5] = mk(1, 5'h10, 1); din[4] = mk(1, 5'h06, 1);
        din[3] = mk(1, 5'h07, 1); din[2] = mk(1, 5'h08, 1);
        din[1] = mk(1, 5'h09, 1); din[0] = mk(1, 5'h0A, 1);
        do_reset();
        for (int c = 1; c <= 2 * FRAME + 1; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_bad++;
                $display("FAIL full_model n=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         n, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            // Frame 1 spans n = 2+FRAME .. 1+2*FRAME.
            if (c >= 2 + FRAME) begin
                int k, off;
                k   = (c - 2 - FRAME) / SD;
                off = (c - 2 - FRAME) % SD;
                n_cmp++;
                if (off < BC) begin
                    if (an !== 8'hFF) begin
                        n_bad++;
                        $display("FAIL full_blank slot=%0d off=%0d got an=%h want FF", k, off, an);
                    end
                end else if (an !== ~(8'd1 << k) || seg !== want_seg[k]) begin
                    n_bad++;
                    $display("FAIL full_walk slot=%0d off=%0d got an=%h seg=%h want an=%h seg=%h",
                             k, off, an, seg, ~(8'd1 << k), want_seg[k]);
                end
            end
        end
    endtask

    task automatic test_disabled_dp();
        int dp_low;
        for (int k = 0; k < 8; k++) din[k] = mk(1, 5'($urandom_range(0, 16)), 1);
        din[2] = mk(0, 5'h03, 0);
        din[0] = mk(1, 5'h03, 0);
        do_reset();
        dp_low = 0;
        for (int c = 1; c <= 2 * FRAME + 1; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_bad++;
                $display("FAIL dis_model n=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         n, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            n_cmp++;
            if (an[2] !== 1'b1 || (an !== 8'hFF && !$onehot(~an))) begin
                n_bad++;
                $display("FAIL dis_anode n=%0d got an=%h want an[2]=1 and one-hot", n, an);
            end
            if (dp === 1'b0) begin
                dp_low++;
                n_cmp++;
                if (an !== 8'hFE) begin
                    n_bad++;
                    $display("FAIL dp_slot n=%0d got an=%h want FE while dp low", n, an);
                end
            end
        end
        n_cmp++;
        if (dp_low != 2 * (SD - BC)) begin
            n_bad++;
            $display("FAIL dp_count got %0d want %0d", dp_low, 2 * (SD - BC));
        end
    endtask

    task automatic test_snapshot();
        for (int k = 0; k < 8; k++) din[k] = mk(1, 5'($urandom_range(0, 31)), 1'($urandom));
        din[4] = mk(1, 5'h07, 1);
        do_reset();
        for (int c = 1; c <= 2 * FRAME + 1; c++) begin
            @(negedge clock);
            if (c == 20) din[4] = mk(1, 5'h0D, 1);  // mid-frame, while idx=2
            n_cmp++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_bad++;
                $display("FAIL snap_model n=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         n, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (c == 2 + 4 * SD + BC) begin
                n_cmp++;
                if (an !== 8'hEF || seg !== 7'h06) begin
                    n_bad++;
                    $display("FAIL snap_old got an=%h seg=%h want EF/06", an, seg);
                end
            end
            if (c == 2 + FRAME + 4 * SD + BC) begin
                n_cmp++;
                if (an !== 8'hEF || seg !== 7'h47) begin
                    n_bad++;
                    $display("FAIL snap_new got an=%h seg=%h want EF/47", an, seg);
                end
            end
        end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 8; k++) din[k] = 7'($urandom);
        din[1] = mk(1, 5'h1A, 1);
        do_reset();
        for (int c = 1; c <= FRAME + 1; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_bad++;
                $display("FAIL illegal_model n=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         n, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (c == 2 + SD + BC + 1) begin
                n_cmp++;
                if (an !== 8'hFD || seg !== 7'h7F) begin
                    n_bad++;
                    $display("FAIL illegal_code got an=%h seg=%h want FD/7F", an, seg);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 8; k++) din[k] = mk(1, 5'($urandom_range(0, 15)), 1'($urandom));
        do_reset();
        // After edge 45 the state is idx=5, cnt=4.
        for (int c = 1; c <= 45; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_bad++;
                $display("FAIL mid_pre n=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         n, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
        end
        n_cmp++;
        if (an !== 8'hDF) begin
            n_bad++;
            $display("FAIL mid_lit got an=%h want DF", an);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({an, seg, dp, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_async got %h/%h/%b/%b want FF/7F/1/0", an, seg, dp, frame_start);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) din[k] = mk(1, 5'($urandom_range(0, 31)), 1'($urandom));
        for (int c = 1; c <= FRAME + 1; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_bad++;
                $display("FAIL mid_post n=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         n, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (c == 2 + BC) begin
                n_cmp++;
                if (an !== 8'hFE) begin
                    n_bad++;
                    $display("FAIL mid_restart got an=%h want FE", an);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 1; c <= 4 * FRAME; c++) begin
            @(negedge clock);
            for (int k = 0; k < 8; k++) din[k] = 7'($urandom);
            n_cmp++;
            if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_bad++;
                $display("FAIL b2b_model n=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         n, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) din[k] = 7'h21;
        test_reset();
        test_full_pattern();
        test_disabled_dp();
        test_snapshot();
        test_illegal();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
